// File: rtl/adc_pkg.sv
// -----------------------------------------------------------------------------
// adc_pkg
// Shared types and constants for the ADC sample framer (adc_frame_buf).
//   sample_u_t   : raw 12-bit unsigned ADC code (0..4095)
//   sample_s_t   : 12-bit two's complement sample centred on mid-scale
//   ADC_MIDSCALE : code subtracted to centre the unsigned code on zero
//   rd_state_t   : read-side bank state {EMPTY, FULL, READING}
//   to_signed()  : unsigned code -> signed sample about mid-scale
// Build option: ADC_FRAME_DECIM_EN (used by adc_decim; nothing here depends on it).
// -----------------------------------------------------------------------------
package adc_pkg;

  typedef logic [11:0]        sample_u_t;
  typedef logic signed [11:0] sample_s_t;

  localparam sample_u_t ADC_MIDSCALE = 12'd2048;

  // EMPTY   : read bank free, nothing to pop
  // FULL    : complete frame held, no pop yet
  // READING : at least one sample of the held frame popped
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    READING = 2'd2
  } rd_state_t;

  // Offset conversion: the 12-bit wrap of (code - 2048) is exactly the
  // two's complement value in -2048..+2047, so no saturation is needed.
  function automatic sample_s_t to_signed(input sample_u_t code);
    return sample_s_t'(code - ADC_MIDSCALE);
  endfunction

endpackage

// File: rtl/adc_frame_buf_if.sv
// -----------------------------------------------------------------------------
// adc_frame_buf_if
// Bundles the sample input, the pop handshake and the status/debug outputs of
// adc_frame_buf.
//   master : testbench / upstream+downstream side (drives in_strobe, in_data,
//            rd_en; observes everything else)
//   slave  : adc_frame_buf side
// Handshake: in_strobe is a one-cycle qualifier for in_data (no back-pressure).
// A pop is accepted in any cycle where rd_en && frame_valid; the popped sample
// appears on out_data with out_valid exactly one cycle later, out_last marking
// the final sample of the frame. rd_en without frame_valid is ignored.
// rd_state exposes the read FSM for debug/checkers.
// Build option: ADC_FRAME_DECIM_EN (does not change this interface).
// -----------------------------------------------------------------------------
interface adc_frame_buf_if;
  import adc_pkg::*;

  logic      in_strobe;
  sample_u_t in_data;
  logic      rd_en;
  logic      frame_valid;
  logic      out_valid;
  sample_s_t out_data;
  logic      out_last;
  logic      overrun;
  rd_state_t rd_state;

  modport master (
    output in_strobe, in_data, rd_en,
    input  frame_valid, out_valid, out_data, out_last, overrun, rd_state
  );

  modport slave (
    input  in_strobe, in_data, rd_en,
    output frame_valid, out_valid, out_data, out_last, overrun, rd_state
  );

endinterface

// File: rtl/adc_decim.sv
// -----------------------------------------------------------------------------
// adc_decim
// Input path of the framer: optional block-average decimation followed by the
// mid-scale offset conversion. Emits a one-cycle st_valid strobe with the value
// to store, registered one cycle after the qualifying in_strobe.
//   clk, reset (async, active-low)
//   in_strobe, in_data : raw ADC sample and its qualifier
//   st_valid, st_data  : value to write into the frame bank
// Build option ADC_FRAME_DECIM_EN:
//   defined   - average every DECIM strobes ((12+log2 DECIM)-bit accumulator)
//   undefined - every strobe stores in_data - 2048, no accumulator is built
// -----------------------------------------------------------------------------
module adc_decim
  import adc_pkg::*;
#(
  parameter int DECIM = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      in_strobe,
  input  sample_u_t in_data,
  output logic      st_valid,
  output sample_s_t st_data
);

  if ((DECIM < 1) || (DECIM > 16) || ((DECIM & (DECIM - 1)) != 0)) begin : g_bad_decim
    $error("adc_decim: DECIM must be a power of 2 in 1..16");
  end

`ifdef ADC_FRAME_DECIM_EN

  localparam int LOG2D = $clog2(DECIM);
  // Counter needs at least one bit even when DECIM == 1.
  localparam int CW    = (LOG2D > 0) ? LOG2D : 1;
  localparam int AW    = 12 + LOG2D;

  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [AW-1:0] sum;
  logic          block_done;
  sample_u_t     avg;

  always_comb begin
    sum        = acc + AW'(in_data);
    block_done = (cnt == CW'(DECIM - 1));
    // Shift by log2(DECIM) is the floor of the block mean; it always fits
    // 12 bits because the sum of DECIM 12-bit codes fits AW bits.
    avg        = sample_u_t'(sum >> LOG2D);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      cnt      <= '0;
      st_valid <= 1'b0;
      st_data  <= '0;
    end else begin
      st_valid <= 1'b0;
      if (in_strobe) begin
        if (block_done) begin
          acc      <= '0;
          cnt      <= '0;
          st_valid <= 1'b1;
          st_data  <= to_signed(avg);
        end else begin
          acc <= sum;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

`else

  // Pass-through: one stored value per strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_valid <= 1'b0;
      st_data  <= '0;
    end else begin
      st_valid <= in_strobe;
      if (in_strobe) begin
        st_data <= to_signed(in_data);
      end
    end
  end

`endif

endmodule

// File: rtl/adc_frame_buf.sv
// -----------------------------------------------------------------------------
// adc_frame_buf
// Frames signed ADC samples into ping-pong banks of FRAME_LEN samples and hands
// complete frames to the consumer through a pop handshake.
//   clk, reset (async, active-low)
//   bus (adc_frame_buf_if.slave):
//     in_strobe/in_data   raw sample input
//     rd_en               pop request, honoured only while frame_valid
//     frame_valid         a complete frame is held in the read bank
//     out_valid/out_data  popped sample, one cycle after the accepted pop
//     out_last            marks the final sample of the frame
//     overrun             sticky: a filled frame was discarded
//     rd_state            read FSM state (debug)
// Parameters: FRAME_LEN (power of 2, 4..1024), DECIM (power of 2, 1..16).
// Build option ADC_FRAME_DECIM_EN enables DECIM block averaging in adc_decim.
// -----------------------------------------------------------------------------
module adc_frame_buf
  import adc_pkg::*;
#(
  parameter int FRAME_LEN = 64,
  parameter int DECIM     = 4
) (
  input  logic            clk,
  input  logic            reset,
  adc_frame_buf_if.slave  bus
);

  if ((FRAME_LEN < 4) || (FRAME_LEN > 1024) ||
      ((FRAME_LEN & (FRAME_LEN - 1)) != 0)) begin : g_bad_len
    $error("adc_frame_buf: FRAME_LEN must be a power of 2 in 4..1024");
  end

  localparam int             IW       = $clog2(FRAME_LEN);
  localparam logic [IW-1:0]  LAST_IDX = IW'(FRAME_LEN - 1);

  // ---------------------------------------------------------------------------
  // Input path
  // ---------------------------------------------------------------------------
  logic      st_valid;
  sample_s_t st_data;

  adc_decim #(
    .DECIM (DECIM)
  ) u_decim (
    .clk       (clk),
    .reset     (reset),
    .in_strobe (bus.in_strobe),
    .in_data   (bus.in_data),
    .st_valid  (st_valid),
    .st_data   (st_data)
  );

  // ---------------------------------------------------------------------------
  // Bank bookkeeping
  // ---------------------------------------------------------------------------
  // One memory holds both banks; the bank bit is the address MSB. The read
  // bank is always the one the writer is not using.
  sample_s_t     mem [2*FRAME_LEN];

  logic          wr_bank;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  rd_state_t     state, state_n;

  logic          frame_valid;
  logic          pop;
  logic          rd_release;
  logic          wr_full;
  logic          bank_free;
  logic          swap;
  logic          ovr_set;

  assign frame_valid     = (state != EMPTY);
  assign bus.frame_valid = frame_valid;
  assign bus.rd_state    = state;

  always_comb begin
    pop        = bus.rd_en && frame_valid;
    // rd_idx only reaches LAST_IDX while READING, so this is the final pop.
    rd_release = pop && (rd_idx == LAST_IDX);
    wr_full    = st_valid && (wr_idx == LAST_IDX);
    // A release in the same cycle counts as a free bank: the new frame is
    // swapped in and frame_valid never drops.
    bank_free  = (state == EMPTY) || rd_release;
    swap       = wr_full && bank_free;
    ovr_set    = wr_full && !bank_free;
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      EMPTY:   if (swap) state_n = FULL;
      FULL:    if (pop) state_n = READING;
      READING: if (rd_release) state_n = swap ? FULL : EMPTY;
      default: state_n = EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write side: on a discarded frame the writer simply restarts at index 0 of
  // the same bank, overwriting the frame that could not be handed over.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (st_valid) begin
      mem[{wr_bank, wr_idx}] <= st_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank     <= 1'b0;
      wr_idx      <= '0;
      bus.overrun <= 1'b0;
    end else begin
      if (st_valid) begin
        wr_idx <= wr_full ? '0 : wr_idx + IW'(1);
      end
      if (swap) begin
        wr_bank <= ~wr_bank;
      end
      if (ovr_set) begin
        bus.overrun <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read side: registered read, one pop per cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_idx        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      bus.out_valid <= pop;
      bus.out_last  <= rd_release;
      if (pop) begin
        bus.out_data <= mem[{~wr_bank, rd_idx}];
        rd_idx       <= rd_release ? '0 : rd_idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_buf.sv
// -----------------------------------------------------------------------------
// tb_adc_frame_buf
// Self-checking bench for adc_frame_buf (FRAME_LEN=64, DECIM=4). The reference
// model keeps every raw strobe value in a queue and derives each stored sample
// as floor(mean of D raw codes) - 2048, D = 4 with ADC_FRAME_DECIM_EN defined
// and 1 otherwise.
// -----------------------------------------------------------------------------
module tb_adc_frame_buf;
  import adc_pkg::*;

  localparam int FRAME_LEN = 64;
`ifdef ADC_FRAME_DECIM_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif
  localparam int NSTR = FRAME_LEN * D;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  adc_frame_buf_if bus ();

  adc_frame_buf #(
    .FRAME_LEN (FRAME_LEN),
    .DECIM     (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int          raw_q[$];
  logic [11:0] exp_q[$];
  logic [11:0] got_d[$];
  bit          got_l[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    bus.in_strobe = 1'b0;
    bus.in_data   = '0;
    bus.rd_en     = 1'b0;
    reset = 1'b0;
    repeat (2) tick;
    reset = 1'b1;
    tick;
    raw_q.delete();
    exp_q.delete();
  endtask

  task automatic strobe(input logic [11:0] v, input int gap);
    bus.in_strobe = 1'b1;
    bus.in_data   = v;
    raw_q.push_back(int'(v));
    tick;
    bus.in_strobe = 1'b0;
    repeat (gap) tick;
  endtask

  task automatic send_rand(input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      strobe(12'($urandom_range(0, 4095)), $urandom_range(0, gap_max));
    end
  endtask

  task automatic wait_fv(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      if (bus.frame_valid) ok = 1'b1;
      else tick;
    end
  endtask

  // Reference: consume one frame's worth of raw strobes.
  task automatic model_frame(input bit keep);
    int sum;
    for (int k = 0; k < FRAME_LEN; k++) begin
      sum = 0;
      for (int j = 0; j < D; j++) sum += raw_q.pop_front();
      if (keep) exp_q.push_back(12'(sum / D - 2048));
    end
  endtask

  // Issue exactly FRAME_LEN accepted pops (random gaps) and collect outputs.
  task automatic drain(input int gap_max);
    int issued;
    int cyc;
    got_d.delete();
    got_l.delete();
    issued = 0;
    cyc    = 0;
    while ((got_d.size() < FRAME_LEN) && (cyc < 8 * FRAME_LEN + 50)) begin
      if ((issued < FRAME_LEN) && bus.frame_valid &&
          ($urandom_range(0, gap_max) == 0)) begin
        bus.rd_en = 1'b1;
        issued++;
      end else begin
        bus.rd_en = 1'b0;
      end
      tick;
      cyc++;
      if (bus.out_valid) begin
        got_d.push_back(bus.out_data);
        got_l.push_back(bus.out_last);
      end
    end
    bus.rd_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    bus.in_strobe = 1'b0;
    bus.in_data   = '0;
    bus.rd_en     = 1'b0;
    reset = 1'b0;
    #2;
    n_tests++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid got %b exp 0", bus.frame_valid); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    n_tests++; if (bus.out_data !== 12'sd0) begin n_fail++; $display("FAIL reset_out_data got %h exp 000", bus.out_data); end
    n_tests++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b exp 0", bus.out_last); end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b exp 0", bus.overrun); end
    repeat (3) tick;
    reset = 1'b1;
    tick;
    raw_q.delete();
    exp_q.delete();
  endtask

  task automatic test_constant;
    for (int i = 0; i < NSTR - 1; i++) strobe(12'hFFF, 0);
    strobe(12'hFFF, 0);
    n_tests++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL const_fv_early got %b exp 0", bus.frame_valid); end
    tick;
    n_tests++; if (bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL const_fv_rise got %b exp 1", bus.frame_valid); end
    model_frame(1'b1);
    drain(0);
    n_tests++; if (got_d.size() != FRAME_LEN) begin n_fail++; $display("FAIL const_count got %0d exp %0d", got_d.size(), FRAME_LEN); end
    for (int i = 0; i < got_d.size(); i++) begin
      logic [11:0] e;
      e = exp_q.pop_front();
      n_tests++; if (got_d[i] !== e) begin n_fail++; $display("FAIL const_data[%0d] got %h exp %h", i, got_d[i], e); end
      n_tests++; if (got_l[i] !== (i == FRAME_LEN - 1)) begin n_fail++; $display("FAIL const_last[%0d] got %b exp %b", i, got_l[i], (i == FRAME_LEN - 1)); end
    end
    n_tests++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL const_fv_fall got %b exp 0", bus.frame_valid); end
  endtask

  task automatic test_ramp;
    bit ok;
    for (int i = 0; i < NSTR; i++) strobe(12'(i), 0);
    wait_fv(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL ramp_fv got 0 exp 1"); end
    model_frame(1'b1);
    drain(0);
    n_tests++; if (got_d.size() != FRAME_LEN) begin n_fail++; $display("FAIL ramp_count got %0d exp %0d", got_d.size(), FRAME_LEN); end
    for (int i = 0; i < got_d.size(); i++) begin
      logic [11:0] e;
      e = exp_q.pop_front();
      n_tests++; if (got_d[i] !== e) begin n_fail++; $display("FAIL ramp_data[%0d] got %h exp %h", i, got_d[i], e); end
      n_tests++; if (got_l[i] !== (i == FRAME_LEN - 1)) begin n_fail++; $display("FAIL ramp_last[%0d] got %b exp %b", i, got_l[i], (i == FRAME_LEN - 1)); end
    end
  endtask

  task automatic test_random;
    bit ok;
    for (int f = 0; f < 2; f++) begin
      send_rand(NSTR, 2);
      wait_fv(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rand_fv[%0d] got 0 exp 1", f); end
      model_frame(1'b1);
      drain(3);
      n_tests++; if (got_d.size() != FRAME_LEN) begin n_fail++; $display("FAIL rand_count got %0d exp %0d", got_d.size(), FRAME_LEN); end
      for (int i = 0; i < got_d.size(); i++) begin
        logic [11:0] e;
        e = exp_q.pop_front();
        n_tests++; if (got_d[i] !== e) begin n_fail++; $display("FAIL rand_data[%0d] got %h exp %h", i, got_d[i], e); end
        n_tests++; if (got_l[i] !== (i == FRAME_LEN - 1)) begin n_fail++; $display("FAIL rand_last[%0d] got %b exp %b", i, got_l[i], (i == FRAME_LEN - 1)); end
      end
    end
  endtask

  task automatic test_overrun;
    bit ok;
    send_rand(NSTR, 1);
    wait_fv(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL ovr_fv_a got 0 exp 1"); end
    send_rand(NSTR - 1, 0);
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early got %b exp 0", bus.overrun); end
    strobe(12'($urandom_range(0, 4095)), 0);
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pre got %b exp 0", bus.overrun); end
    tick;
    n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_rise got %b exp 1", bus.overrun); end
    n_tests++; if (bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_fv_hold got %b exp 1", bus.frame_valid); end
    model_frame(1'b1);
    model_frame(1'b0);
    drain(1);
    n_tests++; if (got_d.size() != FRAME_LEN) begin n_fail++; $display("FAIL ovr_count got %0d exp %0d", got_d.size(), FRAME_LEN); end
    for (int i = 0; i < got_d.size(); i++) begin
      logic [11:0] e;
      e = exp_q.pop_front();
      n_tests++; if (got_d[i] !== e) begin n_fail++; $display("FAIL ovr_data[%0d] got %h exp %h", i, got_d[i], e); end
      n_tests++; if (got_l[i] !== (i == FRAME_LEN - 1)) begin n_fail++; $display("FAIL ovr_last[%0d] got %b exp %b", i, got_l[i], (i == FRAME_LEN - 1)); end
    end
    tick;
    n_tests++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_fv_after got %b exp 0", bus.frame_valid); end
    n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got %b exp 1", bus.overrun); end
    apply_reset();
  endtask

  // The final pop of frame A is accepted in the same cycle frame B's last
  // stored value is written.
  task automatic test_simultaneous;
    bit          ok;
    int          drops;
    logic [11:0] last_v;
    send_rand(NSTR, 1);
    wait_fv(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL sim_fv_a got 0 exp 1"); end
    model_frame(1'b1);
    send_rand(NSTR - 1, 0);
    last_v = 12'($urandom_range(0, 4095));
    got_d.delete();
    got_l.delete();
    drops = 0;
    for (int i = 0; i < FRAME_LEN + 2; i++) begin
      bus.rd_en     = (i < FRAME_LEN);
      bus.in_strobe = (i == FRAME_LEN - 2);
      bus.in_data   = last_v;
      if (i == FRAME_LEN - 2) raw_q.push_back(int'(last_v));
      tick;
      if (bus.frame_valid !== 1'b1) drops++;
      if (bus.out_valid) begin
        got_d.push_back(bus.out_data);
        got_l.push_back(bus.out_last);
      end
    end
    bus.rd_en     = 1'b0;
    bus.in_strobe = 1'b0;
    n_tests++; if (drops != 0) begin n_fail++; $display("FAIL sim_fv_drops got %0d exp 0", drops); end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL sim_overrun got %b exp 0", bus.overrun); end
    n_tests++; if (got_d.size() != FRAME_LEN) begin n_fail++; $display("FAIL sim_count_a got %0d exp %0d", got_d.size(), FRAME_LEN); end
    for (int i = 0; i < got_d.size(); i++) begin
      logic [11:0] e;
      e = exp_q.pop_front();
      n_tests++; if (got_d[i] !== e) begin n_fail++; $display("FAIL sim_data_a[%0d] got %h exp %h", i, got_d[i], e); end
    end
    model_frame(1'b1);
    drain(0);
    n_tests++; if (got_d.size() != FRAME_LEN) begin n_fail++; $display("FAIL sim_count_b got %0d exp %0d", got_d.size(), FRAME_LEN); end
    for (int i = 0; i < got_d.size(); i++) begin
      logic [11:0] e;
      e = exp_q.pop_front();
      n_tests++; if (got_d[i] !== e) begin n_fail++; $display("FAIL sim_data_b[%0d] got %h exp %h", i, got_d[i], e); end
      n_tests++; if (got_l[i] !== (i == FRAME_LEN - 1)) begin n_fail++; $display("FAIL sim_last_b[%0d] got %b exp %b", i, got_l[i], (i == FRAME_LEN - 1)); end
    end
    n_tests++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL sim_fv_end got %b exp 0", bus.frame_valid); end
  endtask

  task automatic test_idle_rd;
    bit ok;
    int spurious;
    spurious = 0;
    bus.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick;
      if (bus.out_valid !== 1'b0) spurious++;
    end
    bus.rd_en = 1'b0;
    n_tests++; if (spurious != 0) begin n_fail++; $display("FAIL idle_out_valid got %0d exp 0", spurious); end
    send_rand(NSTR, 1);
    wait_fv(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL idle_fv got 0 exp 1"); end
    model_frame(1'b1);
    drain(2);
    n_tests++; if (got_d.size() != FRAME_LEN) begin n_fail++; $display("FAIL idle_count got %0d exp %0d", got_d.size(), FRAME_LEN); end
    for (int i = 0; i < got_d.size(); i++) begin
      logic [11:0] e;
      e = exp_q.pop_front();
      n_tests++; if (got_d[i] !== e) begin n_fail++; $display("FAIL idle_data[%0d] got %h exp %h", i, got_d[i], e); end
      n_tests++; if (got_l[i] !== (i == FRAME_LEN - 1)) begin n_fail++; $display("FAIL idle_last[%0d] got %b exp %b", i, got_l[i], (i == FRAME_LEN - 1)); end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    send_rand(NSTR, 0);
    wait_fv(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rmid_fv_pre got 0 exp 1"); end
    bus.rd_en = 1'b1;
    repeat (3) tick;
    bus.rd_en = 1'b0;
    send_rand(NSTR / 2 + 1, 0);
    #2;
    reset = 1'b0;
    #1;
    n_tests++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_frame_valid got %b exp 0", bus.frame_valid); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid got %b exp 0", bus.out_valid); end
    n_tests++; if (bus.out_data !== 12'sd0) begin n_fail++; $display("FAIL rmid_out_data got %h exp 000", bus.out_data); end
    n_tests++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL rmid_out_last got %b exp 0", bus.out_last); end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL rmid_overrun got %b exp 0", bus.overrun); end
    tick;
    reset = 1'b1;
    tick;
    raw_q.delete();
    exp_q.delete();
    send_rand(NSTR - 1, 1);
    repeat (4) tick;
    n_tests++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_fv_short got %b exp 0", bus.frame_valid); end
    strobe(12'($urandom_range(0, 4095)), 0);
    wait_fv(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rmid_fv_full got 0 exp 1"); end
    model_frame(1'b1);
    drain(0);
    n_tests++; if (got_d.size() != FRAME_LEN) begin n_fail++; $display("FAIL rmid_count got %0d exp %0d", got_d.size(), FRAME_LEN); end
    for (int i = 0; i < got_d.size(); i++) begin
      logic [11:0] e;
      e = exp_q.pop_front();
      n_tests++; if (got_d[i] !== e) begin n_fail++; $display("FAIL rmid_data[%0d] got %h exp %h", i, got_d[i], e); end
      n_tests++; if (got_l[i] !== (i == FRAME_LEN - 1)) begin n_fail++; $display("FAIL rmid_last[%0d] got %b exp %b", i, got_l[i], (i == FRAME_LEN - 1)); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.in_strobe = 1'b0;
    bus.in_data   = '0;
    bus.rd_en     = 1'b0;
    test_reset();
    test_constant();
    test_ramp();
    test_random();
    test_overrun();
    test_simultaneous();
    test_idle_rd();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_frame_buf.md
# adc_frame_buf

Sample framer directly downstream of the ADC SPI interface in the audio analyzer. It:
- consumes the 12-bit unsigned ADC sample and its one-cycle `ready` strobe;
- optionally decimates by block averaging;
- converts to signed two's complement about mid-scale;
- fills ping-pong frame banks of FRAME_LEN samples for the spectral/display stage to read out under a pop handshake.

## Interface
- FRAME_LEN, 64: samples per frame; power of 2, 4..1024
- DECIM, 4: samples averaged per stored sample; power of 2, 1..16 (used only with ADC_FRAME_DECIM_EN)
- clk  in  1  system clock, same domain as the ADC interface
- reset  in  1  asynchronous, active-low
- in_strobe  in  1  one-cycle pulse: in_data holds a new sample
- in_data  in  12  unsigned ADC code, 0..4095
- rd_en  in  1  consumer pops one sample; ignored unless frame_valid
- frame_valid  out  1  a complete frame is held in the read bank
- out_valid  out  1  out_data/out_last valid this cycle
- out_data  out  12  signed sample
- out_last  out  1  qualifies the final sample of a frame
- overrun  out  1  sticky; set when a filled frame is discarded

## Operation
- Reset: every output 0, both banks free, write index 0, accumulator 0. Reset mid-frame discards partial frame and accumulator.
- Input path:
  - each in_strobe adds in_data to a (12+log2 DECIM)-bit accumulator;
  - on the DECIM-th strobe, stored value = (acc >> log2 DECIM) − 2048, as 12-bit signed;
  - the accumulator then clears;
  - range −2048..+2047, no saturation needed.
- Write bank: stored values are written at write index 0..FRAME_LEN−1. At index FRAME_LEN−1 the bank is full.
- Full-bank handling:
  - read bank free: swap banks, assert frame_valid, write index 0;
  - read bank busy: no swap, write index 0, overwrite the current write bank, set overrun.
- Read FSM:
  - EMPTY → FULL on swap.
  - FULL → READING on first rd_en.
  - READING → EMPTY on the pop of index FRAME_LEN−1.
- Pop rule: each rd_en while frame_valid pops the next sample in order.
- Read bank release: happens the cycle the last pop is accepted. frame_valid deasserts the next cycle.
- Simultaneous release and write-bank full in the same cycle: release wins. The swap proceeds, overrun is not set, and frame_valid stays high continuously.
- rd_en while frame_valid=0: ignored, no out_valid.
- Back-to-back in_strobe (every cycle) is legal.

## Timing
- Store: the stored value is written the cycle after the qualifying in_strobe.
- Frame ready: frame_valid rises 1 cycle after the last sample of a frame is written.
- Pop latency: out_valid/out_data appear 1 cycle after an accepted rd_en. This suits registered or inferred RAM read.
- out_last: high with out_valid for index FRAME_LEN−1.
- Throughput: one pop per cycle sustained. A frame drains in FRAME_LEN cycles.
- overrun: rises 1 cycle after the discarding event and stays high until reset.

## Configuration
- ADC_FRAME_DECIM_EN defined: block averaging by DECIM as above.
- Undefined: DECIM ignored; every in_strobe stores in_data − 2048 directly, and no accumulator is built.

## Structure
- adc_pkg:
  - typedef sample_u_t (logic [11:0]) and sample_s_t (logic signed [11:0]);
  - constant ADC_MIDSCALE = 12'd2048;
  - read FSM enum {EMPTY, FULL, READING}.
- Sub-module adc_decim: accumulator, DECIM counter and offset conversion; emits a one-cycle stored-value strobe.
- Banks: a single 2×FRAME_LEN×12 memory addressed {bank, index}.

## Test plan
- Constant 12'hFFF, DECIM=4, FRAME_LEN=64: after 256 strobes frame_valid=1; 64 pops give out_data=+2047 each, out_last only on the 64th.
- Ramp 0,1,2,3,… (DECIM=4): stored sample k = 4k+1 (4k+1.5 truncated) − 2048, i.e. first three −2047, −2043, −2039.
- No pops while 2 frames arrive: overrun sets 1 cycle after the second frame fills, and frame_valid stays 1. The first frame pops intact; the second frame's data was overwritten.
- Last pop timed on the same cycle the next frame completes: overrun stays 0, frame_valid never drops, and the next frame pops intact.
- rd_en held high with frame_valid=0: out_valid stays 0, no index advance.
- Reset asserted mid-frame, then 255 strobes: frame_valid stays 0 and all outputs read 0 at reset. One more strobe gives frame_valid=1 (DECIM=4).
